// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: accepts one load/store,
// freezes the pipeline for LATENCY cycles, then pulses ack_o with load data or a misalignment flag.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Handshake: a request is taken in any IDLE cycle with req_i high (stall_o rises in that
    // same cycle); ack_o is a single-cycle pulse in RESP, the cycle the pipeline may advance.

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [AW+1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             enter_resp;
    logic             rd_we;
    logic [AW+1:0]    rd_addr;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic             unused_addr_hi;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY = 1 the read happens on the accept edge, so it must use the live inputs.
    assign rd_addr        = (state_q == IDLE) ? addr_i[AW+1:0] : addr_q;
    assign rd_we          = (state_q == IDLE) ? we_i : we_q;
    assign rd_idx         = rd_addr[AW+1:2];
    assign wr_idx         = addr_q[AW+1:2];
    assign unused_addr_hi = ^addr_i[31:AW+2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[AW+1:0];
                    wdata_d = wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp && !rd_we) begin
            rdata_d = (rd_addr[1:0] == 2'b00) ? mem[rd_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is not reset; a reset arriving in RESP still suppresses the write.
    always_ff @(posedge clk_i) begin
        if (state_q == RESP && we_q && addr_q[1:0] == 2'b00 && !rst_i) begin
            mem[wr_idx] <= wdata_q;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = (state_q == RESP);
    assign err_o   = (state_q == RESP) && (addr_q[1:0] != 2'b00);
    assign stall_o = !rst_i && (((state_q == IDLE) && req_i) || (state_q == BUSY));
    assign state_o = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: one LATENCY=4 and one LATENCY=1 responder, table-driven transactions
// plus hand-written reset and input-toggling sequences.
module tb_data_memory_responder;
    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        stall [2];
    logic        err   [2];
    logic [1:0]  st    [2];

    int n_cmp  = 0;
    int n_fail = 0;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .stall_o(stall[0]),
        .err_o(err[0]), .state_o(st[0])
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .stall_o(stall[1]),
        .err_o(err[1]), .state_o(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one request at a negedge; cycle 0 is the request cycle, cycle k follows the k-th edge.
    task automatic txn(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit toggle, output logic [31:0] rd, output logic er,
                       output int lat, output int stalls);
        bit done;
        done = 0; lat = -1; stalls = 0; rd = 32'hx; er = 1'bx;
        @(negedge clk);
        req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d;
        #1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req[sel] = 1'b0;
                if (toggle) begin
                    addr[sel]  = $urandom_range(0, 32'hFFFF);
                    wdata[sel] = $urandom;
                    we[sel]    = $urandom_range(0, 1);
                end
                #1;
            end
            if (stall[sel]) stalls++;
            if (ack[sel]) begin
                lat = c; rd = rdata[sel]; er = err[sel]; done = 1;
            end
        end
    endtask

    typedef struct {
        int          sel;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_stalls;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, stalls, acks;

        vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0, 4, 4};
        vecs[1]  = '{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 4, 4};
        vecs[2]  = '{0, 0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1, 4, 4};
        vecs[3]  = '{0, 1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 0, 4, 4};
        vecs[4]  = '{0, 1, 32'h0000_0022, 32'h0000_0055, 32'h0000_0000, 1, 4, 4};
        vecs[5]  = '{0, 0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 0, 4, 4};
        vecs[6]  = '{0, 1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hCAFE_F00D, 0, 4, 4};
        vecs[7]  = '{0, 0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 0, 4, 4};
        vecs[8]  = '{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 4, 4};
        vecs[9]  = '{0, 1, 32'h0000_03FC, 32'h0000_0001, 32'hDEAD_BEEF, 0, 4, 4};
        vecs[10] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 0, 4, 4};
        vecs[11] = '{1, 1, 32'h0000_0008, 32'h1111_2222, 32'h0000_0000, 0, 1, 1};
        vecs[12] = '{1, 0, 32'h0000_0008, 32'h0,         32'h1111_2222, 0, 1, 1};
        vecs[13] = '{1, 0, 32'h0000_0009, 32'h0,         32'h0000_0000, 1, 1, 1};

        // clock/reset
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_rdata[%0d]", i), rdata[i], 32'd0);
            chk($sformatf("reset_ack[%0d]", i),   {31'd0, ack[i]}, 32'd0);
            chk($sformatf("reset_stall[%0d]", i), {31'd0, stall[i]}, 32'd0);
            chk($sformatf("reset_err[%0d]", i),   {31'd0, err[i]}, 32'd0);
            chk($sformatf("reset_state[%0d]", i), {30'd0, st[i]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, rd, er, lat, stalls);
            chk($sformatf("vec%0d_rdata", i),  rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i),    {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i),    lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
        end

        // reset two cycles into a store: outputs clear at once, no ack, no write
        txn(0, 1'b1, 32'h0000_0008, 32'hAAAA_0000, 1'b0, rd, er, lat, stalls);
        chk("rst_pre_store_lat", lat, 4);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0008; wdata[0] = 32'h1234_5678;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_busy_stall", {31'd0, stall[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_state", {30'd0, st[0]}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall[0]}, 32'd0);
        chk("rst_mid_rdata", rdata[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (ack[0]) acks++;
        end
        chk("rst_mid_no_ack", acks, 0);
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, er, lat, stalls);
        chk("rst_mid_old_value", rd, 32'hAAAA_0000);

        // simultaneous reset and request: request is dropped
        @(negedge clk);
        rst = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0008; wdata[0] = 32'hFFFF_FFFF;
        #1;
        chk("rst_req_stall", {31'd0, stall[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req[0] = 1'b0;
        #1;
        chk("rst_req_state", {30'd0, st[0]}, 32'd0);
        acks = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (ack[0]) acks++;
        end
        chk("rst_req_no_ack", acks, 0);

        // inputs toggled while busy must not disturb the captured store
        txn(0, 1'b1, 32'h0000_0044, 32'h0BAD_C0DE, 1'b1, rd, er, lat, stalls);
        chk("toggle_store_lat", lat, 4);
        chk("toggle_store_err", {31'd0, er}, 32'd0);
        txn(0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, rd, er, lat, stalls);
        chk("toggle_load_rdata", rd, 32'h0BAD_C0DE);
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, er, lat, stalls);
        chk("toggle_old_word", rd, 32'hAAAA_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Multi-cycle data memory responder for the MEM stage of the 5-stage pipeline.
- Accepts one load or store request per transaction from the MEM stage and returns load data to the MEM stage.
- The MEM stage forwards that data into the MEM/WB pipeline register as ReadData.
- Holds stall_o high while a transaction is in flight, so the upstream pipeline registers freeze until the response arrives.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; power of two, at least 4.
- LATENCY, 4, cycles from request acceptance to ack_o; legal range 1 to 15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  request valid from the MEM stage (MemRead or MemWrite asserted).
- we_i  input  1  1 = store, 0 = load; sampled only on accept.
- addr_i  input  32  byte address; sampled only on accept.
- wdata_i  input  32  store data; sampled only on accept.
- rdata_o  output  32  load data; valid while ack_o is 1, held afterwards.
- ack_o  output  1  one-cycle completion pulse.
- stall_o  output  1  pipeline freeze request.
- err_o  output  1  misaligned-access flag; pulses together with ack_o.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; counter = 0.
  - rdata_o = 0; ack_o = 0; stall_o = 0; err_o = 0.
  - Storage contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req_i = 1, latch we_i, addr_i and wdata_i, then load counter = LATENCY-1.
  - If LATENCY = 1, go to RESP. Otherwise go to BUSY.
  - stall_o is combinational: stall_o = 1 in the same cycle req_i rises in IDLE.
- BUSY:
  - Decrement counter each cycle; go to RESP when counter reaches 1.
  - stall_o = 1.
  - req_i is ignored.
- RESP, exactly one cycle:
  - ack_o = 1; stall_o = 0, so the pipeline advances on this edge.
  - Load: rdata_o = mem[addr[log2(DEPTH_WORDS)+1:2]].
  - Store: mem[index] <= wdata at the end of this cycle; rdata_o holds its previous value.
  - Then return to IDLE.
- Latency: the ack_o rising edge occurs exactly LATENCY cycles after the accept edge.
- Back-to-back: a new request can be accepted in the cycle after RESP, i.e. in IDLE. There is no request pipelining.
- Address rules:
  - Word index uses addr bits [log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - If addr[1:0] != 0, the access is misaligned:
    - The transaction still takes full latency.
    - err_o = 1 in RESP.
    - A store performs no write.
    - A load returns 0 on rdata_o.
- Reads and writes are whole words only; there are no byte enables.
- Changes to req_i, addr_i, we_i or wdata_i during BUSY or RESP have no effect.
- Reset mid-transaction:
  - The transaction is abandoned, no write occurs and no ack_o is issued.
  - The FSM returns to IDLE immediately.
- Simultaneous rst_i and req_i: reset wins and the request is not accepted.

Test Plan:
- Store then load, LATENCY=4: store 0xDEADBEEF to addr 0x10, then load addr 0x10. Required: stall_o high 4 cycles per transaction; ack_o pulses at accept+4; rdata_o = 0xDEADBEEF on the load ack.
- Misaligned access: load addr 0x13 -> err_o = 1 with ack_o, rdata_o = 0. Store 0x55 to 0x22, then load 0x20 -> previous contents unchanged.
- Wrap-around, DEPTH_WORDS=256: store 0xA5A5A5A5 to addr 0x400, then load addr 0x000 -> 0xA5A5A5A5.
- Back-to-back and LATENCY=1: issue three requests, each asserted the cycle after the prior ack_o. Required: each ack_o arrives exactly LATENCY cycles after its accept; with LATENCY=1, stall_o is high 1 cycle per request.
- Reset mid-flight: assert rst_i 2 cycles into a store of 0x12345678 to addr 0x8. Required: outputs cleared immediately, no ack_o ever issued; a subsequent load of 0x8 returns the old value.
- Input changes during BUSY: toggle addr_i and wdata_i every cycle while BUSY -> the stored word equals the value captured on the accept edge.
